step_phase_decoder: RTL and testbench
=====================================

Name: step_phase_decoder

Overview:
- Decodes the 4-bit full-step coil pattern driven toward a stepper motor back into step events, direction and a signed absolute position.
- Sits beside the stepper driver instances and taps their coil outputs.
- Uses a debounced limit switch as a homing reference.
- Flags skipped or illegal phase patterns so the claw controller can stop and re-home.

Parameters:
- POS_W, 16: width of the signed position counter.
- IDLE_W, 20: width of the inactivity counter.
- IDLE_CYCLES, 1000000: clk cycles without a step before `moving` deasserts. Must be at most 2^IDLE_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- coil  input  4  coil pattern from the step driver.
- home  input  1  debounced limit switch, level, high when pressed.
- clear_fault  input  1  single-cycle request to leave FAULT.
- position  output  POS_W  signed step count since the last home.
- step_pulse  output  1  one-cycle strobe per decoded step.
- step_dir  output  1  direction of the last step: 1 forward, 0 reverse.
- moving  output  1  a step occurred within the last IDLE_CYCLES cycles.
- fault  output  1  decoder is in FAULT.
- fault_code  output  2  cause of the fault: 01 skip, 10 illegal pattern, 00 none.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all outputs to 0: position, step_pulse, step_dir, moving, fault, fault_code;
  - state to UNLOCKED, synchronizer and filter registers to 0, idle counter to 0.
- Phase encoding:
  - P0=4'b0001, P1=4'b0010, P2=4'b0100, P3=4'b1000.
  - Forward means index+1 mod 4; reverse means index-1 mod 4.
  - 4'b0000 means de-energized.
  - Any other value is illegal.
- Input path:
  - coil passes through a 2-flop synchronizer (s1, s2), then a compare register s3 (s3 <= s2).
  - A sample is accepted only when s2==s3, i.e. stable for 2 synced cycles.
- Latency: a coil change first sampled at edge k produces registered outputs at edge k+3.
- UNLOCKED state:
  - First accepted one-hot pattern → latch its index as last_phase and go to TRACK. No step, position unchanged.
  - Accepted 0000 → stay in UNLOCKED.
  - Accepted illegal pattern → go to FAULT with code 10.
- TRACK state, for each accepted pattern different from the previously accepted one:
  - delta +1 → step_pulse=1, step_dir=1, position+1.
  - delta −1 (3 mod 4) → step_pulse=1, step_dir=0, position−1.
  - delta 2 → go to FAULT, code 01, no position change.
  - 0000 → no step; last_phase held, so re-energizing at the same or an adjacent phase continues tracking.
  - Illegal pattern → go to FAULT, code 10.
- FAULT state:
  - position frozen; step_pulse stays 0.
  - clear_fault → go to UNLOCKED, fault and fault_code cleared the next cycle.
  - Home events are still honoured.
- Position arithmetic:
  - Two's complement, saturating: holds at 2^(POS_W-1)-1 on a forward step and at -2^(POS_W-1) on a reverse step.
  - step_pulse still fires when the position is saturated.
- Homing:
  - A rising edge of home (registered previous value) sets position to 0 the next cycle.
  - A home edge and a step in the same cycle: home wins, position=0, step_pulse still asserted.
  - A steady-high home does not block stepping.
- moving / idle counter:
  - The idle counter clears on step_pulse and otherwise increments, saturating at IDLE_CYCLES.
  - moving = (counter < IDLE_CYCLES) and at least one step since reset.
- step_pulse lasts exactly one cycle and requires a fresh accepted change, so a static pattern never retriggers it.
- clear_fault outside FAULT is ignored.

Test Plan:
- Forward walk: reset, then coil 0001→0010→0100→1000→0001, each held 8 cycles → 4 step_pulses, step_dir=1, position=4; the first step_pulse comes 3 edges after the 0010 sample.
- Reverse plus home: from position=4, step 0001→1000→0100 → position=2, step_dir=0. Then pulse home → position=0 next cycle. Home in the same cycle as a step → position=0.
- Skip fault: in TRACK at P0, apply 0100 → fault=1, fault_code=01, position unchanged. Further steps ignored. clear_fault → fault=0, UNLOCKED; the next one-hot pattern is latched without a step.
- Illegal and glitch: a 1-cycle 0110 glitch between P1 and P2 → filtered, one normal step. 0110 held 4 cycles → fault_code=10.
- Saturation and de-energize: POS_W=4, 9 forward steps → position holds at 7. Insert 0000 for 20 cycles then resume at the next phase → tracking continues without fault.
- Idle and async reset: IDLE_CYCLES=16; after the last step, moving drops at count 16. Assert rst mid-step → all outputs 0 immediately, state UNLOCKED.

Source files
------------

// File: rtl/step_phase_decoder.sv
// Decodes a full-step one-hot coil pattern back into step strobes, direction and a
// saturating signed position, with homing, inactivity tracking and fault detection.
module step_phase_decoder #(
    parameter int POS_W       = 16,
    parameter int IDLE_W      = 20,
    parameter int IDLE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              coil,
    input  logic                    home,
    input  logic                    clear_fault,
    output logic signed [POS_W-1:0] position,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic                    moving,
    output logic                    fault,
    output logic [1:0]              fault_code
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_SKIP    = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL = 2'b10;

    localparam logic [IDLE_W-1:0]       IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    localparam logic signed [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

    state_e                  state_q, state_d;
    logic [3:0]              s1_q, s2_q, s3_q, acc_q;
    logic                    home_q;
    logic [1:0]              phase_q, phase_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    pulse_q, pulse_d;
    logic                    dir_q, dir_d;
    logic [1:0]              code_q, code_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic                    stepped_q;

    logic       sample_ok, fresh, home_edge;
    logic       is_onehot, is_zero, is_illegal;
    logic [1:0] idx, delta;

    // Decode the synchronized pattern into a phase index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        is_onehot = 1'b1;
        is_zero   = 1'b0;
        idx       = 2'd0;
        case (s2_q)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            4'b0000: begin
                is_onehot = 1'b0;
                is_zero   = 1'b1;
            end
            default: is_onehot = 1'b0;
        endcase
    end

    assign is_illegal = !is_onehot && !is_zero;
    assign sample_ok  = (s2_q == s3_q);
    assign fresh      = sample_ok && (s2_q != acc_q);
    assign delta      = idx - phase_q;
    assign home_edge  = home && !home_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (sample_ok && is_onehot)       state_d = ST_TRACK;
                else if (sample_ok && is_illegal) state_d = ST_FAULT;
            end
            ST_TRACK: begin
                if (fresh && is_illegal)                        state_d = ST_FAULT;
                else if (fresh && is_onehot && delta == 2'd2)   state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (clear_fault) state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        pos_d   = pos_q;
        pulse_d = 1'b0;
        dir_d   = dir_q;
        code_d  = code_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (sample_ok && is_onehot)       phase_d = idx;
                else if (sample_ok && is_illegal) code_d  = CODE_ILLEGAL;
            end
            ST_TRACK: begin
                if (fresh && is_illegal) begin
                    code_d = CODE_ILLEGAL;
                end else if (fresh && is_onehot) begin
                    // delta 0 is re-energizing at the held phase after a 0000 gap.
                    case (delta)
                        2'd1: begin
                            pulse_d = 1'b1;
                            dir_d   = 1'b1;
                            phase_d = idx;
                            if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
                        end
                        2'd3: begin
                            pulse_d = 1'b1;
                            dir_d   = 1'b0;
                            phase_d = idx;
                            if (pos_q != POS_MIN) pos_d = pos_q - POS_ONE;
                        end
                        2'd2:    code_d = CODE_SKIP;
                        default: phase_d = phase_q;
                    endcase
                end
            end
            ST_FAULT: begin
                if (clear_fault) code_d = CODE_NONE;
            end
            default: code_d = CODE_NONE;
        endcase
        // Homing overrides any step position update but leaves the strobe intact.
        if (home_edge) pos_d = '0;
    end

    assign idle_d = pulse_d ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            acc_q     <= '0;
            home_q    <= 1'b0;
            phase_q   <= '0;
            pos_q     <= '0;
            pulse_q   <= 1'b0;
            dir_q     <= 1'b0;
            code_q    <= CODE_NONE;
            idle_q    <= '0;
            stepped_q <= 1'b0;
        end else begin
            s1_q      <= coil;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            if (sample_ok) acc_q <= s2_q;
            home_q    <= home;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            pulse_q   <= pulse_d;
            dir_q     <= dir_d;
            code_q    <= code_d;
            idle_q    <= idle_d;
            stepped_q <= stepped_q | pulse_d;
        end
    end

    assign position   = pos_q;
    assign step_pulse = pulse_q;
    assign step_dir   = dir_q;
    assign moving     = stepped_q && (idle_q < IDLE_MAX);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: stimulus pushes expected step/fault events,
// a negedge monitor pops and compares them as the decoder reports them.
module tb_step_phase_decoder;

    localparam int POS_W       = 4;
    localparam int IDLE_W      = 8;
    localparam int IDLE_CYCLES = 16;

    typedef struct {
        bit is_fault;
        bit dir;
        int pos;
        int code;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [3:0]              coil = 4'b0000;
    logic                    home = 1'b0;
    logic                    clear_fault = 1'b0;
    logic signed [POS_W-1:0] position;
    logic                    step_pulse;
    logic                    step_dir;
    logic                    moving;
    logic                    fault;
    logic [1:0]              fault_code;

    ev_t sb[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    bit  fault_prev = 1'b0;

    step_phase_decoder #(
        .POS_W      (POS_W),
        .IDLE_W     (IDLE_W),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coil       (coil),
        .home       (home),
        .clear_fault(clear_fault),
        .position   (position),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .moving     (moving),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic drive(input logic [3:0] p, input int n);
        coil = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_step(input bit dir, input int pos);
        ev_t e;
        e.is_fault = 1'b0;
        e.dir      = dir;
        e.pos      = pos;
        e.code     = 0;
        sb.push_back(e);
    endtask

    task automatic push_fault(input int code, input int pos);
        ev_t e;
        e.is_fault = 1'b1;
        e.dir      = 1'b0;
        e.pos      = pos;
        e.code     = code;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_position"},   int'(position), 0);
        check({tag, "_step_pulse"}, int'(step_pulse), 0);
        check({tag, "_step_dir"},   int'(step_dir), 0);
        check({tag, "_moving"},     int'(moving), 0);
        check({tag, "_fault"},      int'(fault), 0);
        check({tag, "_fault_code"}, int'(fault_code), 0);
    endtask

    // Monitor: every step strobe and every fault entry must match the next queued event.
    always @(negedge clk) begin
        ev_t e;
        if (step_pulse) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_step: got step pos=%0d dir=%0d expected none at %0t",
                         position, step_dir, $time);
            end else begin
                e = sb.pop_front();
                check("ev_kind_step", 0, int'(e.is_fault));
                check("ev_step_dir", int'(step_dir), int'(e.dir));
                check("ev_step_pos", int'(position), e.pos);
            end
        end
        if (fault && !fault_prev) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_fault: got code=%0d expected none at %0t", fault_code, $time);
            end else begin
                e = sb.pop_front();
                check("ev_kind_fault", 1, int'(e.is_fault));
                check("ev_fault_code", int'(fault_code), e.code);
                check("ev_fault_pos", int'(position), e.pos);
            end
        end
        fault_prev = fault;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Forward walk; the first alignment only latches P0
        drive(4'b0001, 8);
        check("latch_no_move", int'(moving), 0);
        check("latch_position", int'(position), 0);
        push_step(1'b1, 1);
        coil = 4'b0010;
        repeat (3) @(posedge clk);
        #1 check("latency_k2_quiet", int'(step_pulse), 0);
        @(posedge clk);
        #1 check("latency_k3_pulse", int'(step_pulse), 1);
        repeat (3) @(posedge clk);
        #1 check("pulse_one_cycle", int'(step_pulse), 0);
        @(posedge clk);
        #1;
        push_step(1'b1, 2); drive(4'b0100, 8);
        push_step(1'b1, 3); drive(4'b1000, 8);
        push_step(1'b1, 4); drive(4'b0001, 8);
        check("fwd_position", int'(position), 4);
        check("fwd_dir", int'(step_dir), 1);
        check("fwd_moving", int'(moving), 1);

        // Reverse, then home
        push_step(1'b0, 3); drive(4'b1000, 8);
        push_step(1'b0, 2); drive(4'b0100, 8);
        check("rev_position", int'(position), 2);
        check("rev_dir", int'(step_dir), 0);
        home = 1'b1;
        @(posedge clk);
        #1 check("home_zero", int'(position), 0);
        repeat (2) @(posedge clk);
        #1 home = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Home edge coincides with a reverse step
        push_step(1'b0, 0);
        coil = 4'b0010;
        repeat (3) @(posedge clk);
        #1 home = 1'b1;
        @(posedge clk);
        #1 check("home_step_pulse", int'(step_pulse), 1);
        check("home_step_pos", int'(position), 0);
        repeat (4) @(posedge clk);
        #1;
        // Steady-high home still allows stepping
        push_step(1'b0, -1); drive(4'b0001, 8);
        home = 1'b0;
        check("home_high_step_pos", int'(position), -1);

        // Skip fault from P0 to P2
        push_fault(1, -1); drive(4'b0100, 8);
        check("skip_fault", int'(fault), 1);
        check("skip_code", int'(fault_code), 1);
        drive(4'b1000, 8);
        drive(4'b0001, 8);
        check("fault_frozen_pos", int'(position), -1);
        clear_fault = 1'b1;
        @(posedge clk);
        #1 clear_fault = 1'b0;
        check("clear_fault", int'(fault), 0);
        check("clear_code", int'(fault_code), 0);
        drive(4'b0001, 8);
        push_step(1'b1, 0); drive(4'b0010, 8);
        check("relock_pos", int'(position), 0);

        // One-cycle glitch is filtered; a held illegal pattern faults
        drive(4'b0110, 1);
        push_step(1'b1, 1); drive(4'b0100, 8);
        check("glitch_no_fault", int'(fault), 0);
        push_fault(2, 1); drive(4'b0110, 4);
        check("illegal_fault", int'(fault), 1);
        check("illegal_code", int'(fault_code), 2);
        drive(4'b0000, 8);
        clear_fault = 1'b1;
        @(posedge clk);
        #1 clear_fault = 1'b0;
        drive(4'b0000, 8);
        check("illegal_cleared", int'(fault), 0);

        // Saturation at +7
        home = 1'b1;
        @(posedge clk);
        #1 home = 1'b0;
        check("rehome_pos", int'(position), 0);
        drive(4'b0001, 8);
        for (int i = 1; i <= 9; i++) begin
            logic [3:0] pats [4];
            pats[0] = 4'b0001; pats[1] = 4'b0010; pats[2] = 4'b0100; pats[3] = 4'b1000;
            push_step(1'b1, (i > 7) ? 7 : i);
            drive(pats[i % 4], 8);
        end
        check("sat_pos", int'(position), 7);

        // De-energize, then resume at the next phase
        drive(4'b0000, 20);
        check("deenergize_no_fault", int'(fault), 0);
        push_step(1'b1, 7); drive(4'b0100, 8);
        check("resume_no_fault", int'(fault), 0);
        check("resume_pos", int'(position), 7);

        // Idle timing after a reverse step
        push_step(1'b0, 6);
        coil = 4'b0010;
        repeat (4) @(posedge clk);
        #1 check("idle_moving_at_step", int'(moving), 1);
        repeat (15) @(posedge clk);
        #1 check("idle_moving_at_15", int'(moving), 1);
        @(posedge clk);
        #1 check("idle_dropped_at_16", int'(moving), 0);
        repeat (5) @(posedge clk);
        #1 check("idle_stays_low", int'(moving), 0);

        // Async reset mid-step: the pending step must never appear
        coil = 4'b0100;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        drive(4'b0100, 8);
        check("post_rst_pos", int'(position), 0);
        check("post_rst_fault", int'(fault), 0);
        push_step(1'b1, 1); drive(4'b1000, 8);
        check("post_rst_step_pos", int'(position), 1);
        check("post_rst_moving", int'(moving), 1);

        repeat (5) @(posedge clk);
        #1 check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
